// File: rtl/fft_out_streamer.sv
// fft_out_streamer: drains one FFT output frame from the wrapper FIFO
// and presents it as an AXI4-Stream master with tlast, count and error.
module fft_out_streamer #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dev_ready,
  input  logic              dev_busy,
  input  logic [DATA_W-1:0] buf2dma_data,
  output logic              buf2dma_data_rd,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_count,
  output logic              protocol_err
);

  localparam int            CW   = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_flush_q;
  logic              r_inflight;
  logic              r_err;
  logic [1:0]        r_occ;
  logic [DATA_W-1:0] r_skid0;
  logic [DATA_W-1:0] r_skid1;
  logic [CW-1:0]     r_issued;
  logic [CW-1:0]     r_sent;
  logic [CNT_W-1:0]  r_count;

  logic       w_pop;
  logic       w_push;
  logic       w_rd;
  logic       w_abort;
  logic       w_start;
  logic       w_last_hs;
  logic [2:0] w_level;

  // Next state, read strobe and skid bookkeeping terms.
  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_abort   = 1'b0;
    w_start   = 1'b0;
    w_pop     = (r_occ != 2'd0) && m_axis_tready;
    w_push    = r_inflight;
    w_last_hs = w_pop && (r_sent == LAST);
    w_level   = {1'b0, r_occ} + {2'b00, r_inflight}
              - {2'b00, w_pop};
    case (r_state)
      S_IDLE: begin
        if (r_flush_q) begin
          w_next  = S_STREAM;
          w_start = 1'b1;
        end
      end
      S_STREAM: begin
        if (!r_flush_q && (r_issued < LEN)) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          w_rd = (r_issued < LEN) && (w_level < 3'd2);
          if (w_last_hs) w_next = S_DONE;
        end
      end
      S_DONE: w_next = S_WAIT;
      S_WAIT: begin
        if (!r_flush_q) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Flush sampling, counters, skid buffer, frame count and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flush_q  <= 1'b0;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
      r_occ      <= 2'd0;
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_issued   <= '0;
      r_sent     <= '0;
      r_count    <= '0;
    end else begin
      r_flush_q <= !dev_ready && !dev_busy;
      if (w_abort) begin
        r_occ      <= 2'd0;
        r_inflight <= 1'b0;
        r_issued   <= '0;
        r_sent     <= '0;
        r_err      <= 1'b1;
      end else begin
        r_inflight <= w_rd;
        if (w_start) begin
          r_issued <= '0;
          r_sent   <= '0;
        end else begin
          if (w_rd)  r_issued <= r_issued + CW'(1);
          if (w_pop) r_sent   <= r_sent + CW'(1);
        end
        case ({w_push, w_pop})
          2'b10: begin
            if (r_occ == 2'd0) r_skid0 <= buf2dma_data;
            else               r_skid1 <= buf2dma_data;
            r_occ <= r_occ + 2'd1;
          end
          2'b01: begin
            r_skid0 <= r_skid1;
            r_occ   <= r_occ - 2'd1;
          end
          2'b11: begin
            if (r_occ == 2'd1) begin
              r_skid0 <= buf2dma_data;
            end else begin
              r_skid0 <= r_skid1;
              r_skid1 <= buf2dma_data;
            end
          end
          default: ;
        endcase
        if (r_state == S_DONE) r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign buf2dma_data_rd = w_rd;
  assign m_axis_tdata    = r_skid0;
  assign m_axis_tvalid   = (r_occ != 2'd0);
  assign m_axis_tlast    = m_axis_tvalid && (r_sent == LAST);
  assign frame_done      = (r_state == S_DONE);
  assign frame_count     = r_count;
  assign protocol_err    = r_err;

endmodule

// File: tb/tb_fft_out_streamer.sv
// tb_fft_out_streamer: directed frames against a queue-based model of
// the streamer, plus literal per-frame expectations.
module tb_fft_out_streamer;

  localparam int DW = 32;
  localparam int FL = 32;
  localparam int P_IDLE = 0, P_STREAM = 1, P_DONE = 2, P_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dev_ready = 1'b1;
  logic          dev_busy = 1'b0;
  logic          tready = 1'b1;
  logic [DW-1:0] fifo_data = '0;

  logic          rd, tvalid, tlast, done, perr;
  logic [DW-1:0] tdata;
  logic [15:0]   fcnt;
  logic          rd2, tvalid2, tlast2, done2, perr2;
  logic [DW-1:0] tdata2;
  logic [1:0]    fcnt2;

  fft_out_streamer #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .dev_ready(dev_ready), .dev_busy(dev_busy),
    .buf2dma_data(fifo_data), .buf2dma_data_rd(rd),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .frame_done(done), .frame_count(fcnt), .protocol_err(perr)
  );

  fft_out_streamer #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .dev_ready(dev_ready), .dev_busy(dev_busy),
    .buf2dma_data(fifo_data), .buf2dma_data_rd(rd2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready), .m_axis_tlast(tlast2),
    .frame_done(done2), .frame_count(fcnt2), .protocol_err(perr2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // wrapper output FIFO: one-cycle read latency
  logic [DW-1:0] fifo_q[$];
  always @(posedge clk) begin
    if (rd) begin
      if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
      else                   fifo_data <= 32'hDEADBEEF;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // model state
  int            ph = P_IDLE;
  bit            m_fq, m_infl, m_err;
  int            m_iss, m_sent, m_cnt;
  logic [DW-1:0] mq[$];
  bit            armed = 1'b0;
  bit            ev, ep, er, ab, nfq;

  // monitors
  int            rd_cnt, hs_cnt, tlast_cnt, done_cnt, first_rd, flush_cyc;
  logic [DW-1:0] sb_base, tlast_data, prev_data;
  bit            prev_stall;

  always @(negedge clk) begin
    ev = mq.size() != 0;
    ep = ev && tready;
    ab = (ph == P_STREAM) && !m_fq && (m_iss < FL);
    er = (ph == P_STREAM) && !ab && (m_iss < FL) &&
         (mq.size() + int'(m_infl) - int'(ep) < 2);
    if (armed) begin
      chk("rd", rd, er);
      chk("tvalid", tvalid, ev);
      if (ev) chk("tdata", tdata, mq[0]);
      chk("tlast", tlast, ev && (m_sent == FL - 1));
      chk("frame_done", done, ph == P_DONE);
      chk("frame_count", fcnt, m_cnt % 65536);
      chk("frame_count_w2", fcnt2, m_cnt % 4);
      chk("protocol_err", perr, m_err);
      if (prev_stall && tvalid) chk("stall_stable", tdata, prev_data);
      if (rd) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (tvalid && tready) begin
        chk("beat_data", tdata, sb_base + 32'(hs_cnt));
        hs_cnt++;
        if (tlast) begin
          tlast_cnt++;
          tlast_data = tdata;
        end
      end
      if (done) done_cnt++;
    end
    prev_stall = tvalid && !tready && !rst;
    prev_data  = tdata;
    nfq = !dev_ready && !dev_busy;
    if (rst) begin
      ph = P_IDLE;
      mq.delete();
      m_infl = 0; m_iss = 0; m_sent = 0;
      m_cnt = 0; m_err = 0; m_fq = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          if (m_fq) begin
            ph = P_STREAM; m_iss = 0; m_sent = 0;
          end
        end
        P_STREAM: begin
          if (ab) begin
            ph = P_IDLE; mq.delete();
            m_infl = 0; m_iss = 0; m_sent = 0; m_err = 1;
          end else begin
            if (ep) begin
              void'(mq.pop_front());
              if (m_sent == FL - 1) ph = P_DONE;
              m_sent++;
            end
            if (m_infl) mq.push_back(fifo_data);
            m_infl = er;
            if (er) m_iss++;
          end
        end
        P_DONE: begin
          m_cnt++; ph = P_WAIT;
        end
        default: if (!m_fq) ph = P_IDLE;
      endcase
      m_fq = nfq;
    end
    armed = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] base);
    fifo_q.delete();
    for (int i = 0; i < FL; i++) fifo_q.push_back(base + 32'(i));
    sb_base = base; hs_cnt = 0; rd_cnt = 0; tlast_cnt = 0;
    done_cnt = 0; first_rd = -1;
  endtask

  task automatic run_frame(input logic [DW-1:0] base, input int mode,
                           input int exp_cnt, input int exp_cnt2);
    int n;
    load(base);
    flush_cyc = cyc;
    dev_ready = 1'b0;
    dev_busy  = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      tick();
      n++;
      case (mode)
        1:       tready = (n % 4 == 1) || (n % 4 == 0);
        2:       tready = 1'($urandom_range(0, 1));
        default: tready = 1'b1;
      endcase
    end
    tready = 1'b1;
    chk("frame_timeout", 64'(done_cnt != 0), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("rd_latency", 64'(first_rd - flush_cyc), 2);
    chk("rd_pulses", rd_cnt, FL);
    chk("beats", hs_cnt, FL);
    chk("tlast_count", tlast_cnt, 1);
    chk("tlast_data", tlast_data, base + 32'h1F);
    chk("done_pulses", done_cnt, 1);
    chk("count_lit", fcnt, exp_cnt);
    chk("count_w2_lit", fcnt2, exp_cnt2);
    dev_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    int n;
    first_rd = -1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    chk("rst_rd", rd, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_done", done, 0);
    chk("rst_err", perr, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_tdata", tdata, 0);
    tick();

    // nominal frame
    run_frame(32'h0000_0000, 0, 1, 1);
    // backpressure: 1,0,0,1 pattern, then random
    run_frame(32'h0000_0000, 1, 2, 2);
    run_frame(32'h0000_0000, 2, 3, 3);
    // back-to-back frames separated by 3 idle cycles
    run_frame(32'h0000_0100, 0, 4, 0);
    run_frame(32'h0000_0200, 0, 5, 1);

    // early flush drop after 10 reads
    load(32'h0000_0300);
    dev_ready = 1'b0;
    n = 0;
    while (rd_cnt < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("drop_reads_seen", 64'(rd_cnt >= 10), 1);
    dev_ready = 1'b1;
    tick();
    tick();
    chk("drop_tvalid_off", tvalid, 0);
    chk("drop_err_set", perr, 1);
    for (int i = 0; i < 10; i++) tick();
    chk("drop_err_sticky", perr, 1);
    chk("drop_no_done", done_cnt, 0);
    chk("drop_count_held", fcnt, 5);
    run_frame(32'h0000_0400, 0, 6, 2);

    // reset mid-frame after 5 handshakes
    load(32'h0000_0500);
    dev_ready = 1'b0;
    n = 0;
    while (hs_cnt < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_hs_seen", 64'(hs_cnt >= 5), 1);
    rst = 1'b1;
    dev_ready = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rd", rd, 0);
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tlast", tlast, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", perr, 0);
    chk("mid_rst_count", fcnt, 0);
    chk("mid_rst_count_w2", fcnt2, 0);
    chk("mid_rst_tdata", tdata, 0);
    for (int i = 0; i < 3; i++) tick();

    // five frames after reset: narrow counter goes 1,2,3,0,1
    run_frame(32'h0000_0600, 0, 1, 1);
    run_frame(32'h0000_0700, 2, 2, 2);
    run_frame(32'h0000_0800, 1, 3, 3);
    run_frame(32'h0000_0900, 0, 4, 0);
    run_frame(32'h0000_0A00, 2, 5, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
